// File: rtl/irq_pkg.sv
// irq_pkg: shared types, limits and sizing helper for the priority interrupt controller.
package irq_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        SERVICE
    } state_t;

    // Channel index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_prio_select.sv
// irq_prio_select: qualify channels against mask/threshold and pick the highest-priority one.
// Ports:
//   pend_i  pending request bits
//   mask_i  1 = channel blocked
//   prio_i  per-channel priority (0 = disabled)
//   thr_i   a channel qualifies only above this value
//   qual_o  per-channel qualification
//   id_o    winning channel index (lowest index on a tie)
//   vld_o   at least one channel qualifies
module irq_prio_select #(
    parameter int N_CH   = 4,
    parameter int PRIO_W = 4,
    parameter int ID_W   = 2
) (
    input  logic [N_CH-1:0]             pend_i,
    input  logic [N_CH-1:0]             mask_i,
    input  logic [N_CH-1:0][PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]           thr_i,
    output logic [N_CH-1:0]             qual_o,
    output logic [ID_W-1:0]             id_o,
    output logic                        vld_o
);

    logic [PRIO_W-1:0] best;
    logic              q;

    // Ascending scan with a strict compare keeps the lowest index on ties.
    always_comb begin
        qual_o = '0;
        id_o   = '0;
        vld_o  = 1'b0;
        best   = '0;
        q      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            q         = pend_i[i] && !mask_i[i] && (prio_i[i] != '0) && (prio_i[i] > thr_i);
            qual_o[i] = q;
            if (q && (!vld_o || prio_i[i] > best)) begin
                vld_o = 1'b1;
                best  = prio_i[i];
                id_o  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: programmable-priority interrupt controller with IACK/EOI handshake.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   irq_in       raw request lines
//   irq_mask     1 = channel blocked from arbitration (pending still recorded)
//   prio_we/sel/wdata  priority register write port
//   threshold    channels must have priority strictly above this
//   irq_out      interrupt to the core (high while in ASSERT)
//   irq_id       latched channel index
//   iack, eoi    acknowledge / end-of-interrupt pulses from the core
//   in_service   high between accepted iack and eoi
//   clr_ack      one-hot one-cycle pulse on the acknowledged channel
// Build option: define IRQ_EDGE_EN for rising-edge request detection; default is level mode.
module irq_prio_ctrl
    import irq_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int PRIO_W = 4,
    parameter int ID_W   = id_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   irq_in,
    input  logic [N_CH-1:0]   irq_mask,
    input  logic              prio_we,
    input  logic [ID_W-1:0]   prio_sel,
    input  logic [PRIO_W-1:0] prio_wdata,
    input  logic [PRIO_W-1:0] threshold,
    output logic              irq_out,
    output logic [ID_W-1:0]   irq_id,
    input  logic              iack,
    input  logic              eoi,
    output logic              in_service,
    output logic [N_CH-1:0]   clr_ack
);

    state_t                     state_q, state_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic [N_CH-1:0]            pend_q, pend_d;
    logic [N_CH-1:0]            clr_q;
    logic [N_CH-1:0][PRIO_W-1:0] prio_q;
    logic [N_CH-1:0]            qual;
    logic [ID_W-1:0]            win_id;
    logic                       win_vld;
    logic                       ack;
    logic [N_CH-1:0]            ack_vec;

    assign ack     = (state_q == ASSERT) && iack;
    assign ack_vec = ack ? (N_CH'(1) << id_q) : '0;

`ifdef IRQ_EDGE_EN
    logic [N_CH-1:0] in_d_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) in_d_q <= '0;
        else     in_d_q <= irq_in;

    // New edges are OR-ed in after the clear so a same-cycle set wins.
    assign pend_d = (pend_q & ~ack_vec) | (irq_in & ~in_d_q);
`else
    assign pend_d = irq_in & ~ack_vec;
`endif

    irq_prio_select #(
        .N_CH  (N_CH),
        .PRIO_W(PRIO_W),
        .ID_W  (ID_W)
    ) u_sel (
        .pend_i(pend_q),
        .mask_i(irq_mask),
        .prio_i(prio_q),
        .thr_i (threshold),
        .qual_o(qual),
        .id_o  (win_id),
        .vld_o (win_vld)
    );

    // The latched id only changes on IDLE exit, so there is no preemption.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: if (win_vld) begin
                state_d = ASSERT;
                id_d    = win_id;
            end
            ASSERT:  state_d = iack ? SERVICE : (qual[id_q] ? ASSERT : IDLE);
            SERVICE: state_d = eoi ? IDLE : SERVICE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            pend_q  <= '0;
            clr_q   <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            clr_q   <= ack_vec;
            if (prio_we && (int'(prio_sel) < N_CH))
                prio_q[prio_sel] <= prio_wdata;
        end
    end

    assign irq_out    = (state_q == ASSERT);
    assign in_service = (state_q == SERVICE);
    assign irq_id     = id_q;
    assign clr_ack    = clr_q;

endmodule
